press_classifier: RTL and testbench
===================================

// Module: press_classifier
// PURPOSE
//  - Consumes the debounced level from the digital filter stage and classifies
//    each user press as short, double or long.
//  - Emits one-cycle event pulses to the control logic downstream.
//  - Pure sampling block: single clock domain, no CDC.
//    Input is already glitch-free and synchronous to clk.
// PARAMETERS
//  LONG_CYCLES    1000  high samples (consecutive) that qualify a long press; >=2
//  DOUBLE_GAP      200  max low samples between presses for a double press; >=1
//  REPEAT_CYCLES   100  auto-repeat period while long-held (PRESS_REPEAT_EN only); >=1
//  CNT_W            16  counter width; must hold max(LONG_CYCLES, DOUBLE_GAP, REPEAT_CYCLES)
// PORTS
//  clk           in   1  system clock, all logic on rising edge
//  rst           in   1  synchronous, active-high reset
//  sig_in        in   1  filtered (debounced) level, 1 = pressed
//  short_press   out  1  one-cycle pulse: single press ended, no follow-up
//  double_press  out  1  one-cycle pulse: second press started within gap
//  long_press    out  1  one-cycle pulse: press held LONG_CYCLES samples
//  repeat_press  out  1  one-cycle auto-repeat pulse (tied 0 without macro)
//  busy          out  1  1 whenever FSM is not IDLE
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge)
//    - FSM->IDLE, cnt=0, all outputs 0.
//    - Overrides any state mid-operation.
//    - No event is emitted for an interrupted press.
//  - Outputs are registered. Event pulses are mutually exclusive and last exactly 1 cycle.
//  - A "sample" is the value of sig_in at a rising clk edge.
//  - States: IDLE, PRESS1, GAP, PRESS2, HELD.
//  - IDLE
//    - sample=1 -> PRESS1, cnt=1.
//    - sig_in high when reset is released counts as a press.
//  - PRESS1
//    - sample=1: cnt++.
//    - When cnt reaches LONG_CYCLES: long_press=1 next cycle, -> HELD.
//    - sample=0 before that -> GAP, cnt=1 (this low counts as the first gap sample).
//    - A press of LONG_CYCLES-1 samples takes the short/double path.
//  - GAP
//    - sample=0: cnt++.
//    - When cnt reaches DOUBLE_GAP: short_press=1 next cycle, -> IDLE.
//    - sample=1 before that: double_press=1 next cycle, -> PRESS2.
//    - A high sample on the edge after the gap expires starts a fresh PRESS1.
//      No sample is lost.
//  - PRESS2
//    - Waits for sample=0 -> IDLE.
//    - No long detection and no further events.
//    - A third fast press is a new sequence.
//  - HELD
//    - Waits for sample=0 -> IDLE.
//    - No short_press is emitted on release.
//  - Counter never wraps.
//    - It saturates at its terminal value.
//    - It is cleared on every state change.
//  - busy = (state != IDLE), registered with the state.
// CONFIGURATION
//  - PRESS_REPEAT_EN defined
//    - In HELD, repeat_press pulses every REPEAT_CYCLES high samples.
//    - The first pulse comes REPEAT_CYCLES samples after long_press.
//    - Repeat counter restarts after each pulse; release stops pulses immediately.
//  - PRESS_REPEAT_EN undefined
//    - repeat_press is constant 0 and no repeat counter is built.
// TESTING  (LONG_CYCLES=8, DOUBLE_GAP=4, REPEAT_CYCLES=3)
//  - Short press: sig_in high 3 samples, then low.
//    -> short_press pulse 1 cycle after the 4th low sample.
//    -> no other events; busy drops with the pulse.
//  - Double press: high 3, low 2, high 2, low.
//    -> double_press 1 cycle after the first high of press 2.
//    -> no short_press; FSM returns to IDLE on release.
//  - Long boundary, high 7 samples then low.
//    -> short_press only after the gap.
//  - Long boundary, high 8 samples.
//    -> long_press 1 cycle after the 8th high; no event on release.
//  - Repeat, macro on, high 16 samples.
//    -> long_press at sample 8; repeat_press at samples 11 and 14.
//    -> repeat_press stays 0 with macro off.
//  - Reset mid-op: assert rst in PRESS1 at cnt=5 and in GAP.
//    -> all outputs 0 next cycle, busy=0.
//    -> no pulse afterwards with sig_in low.

Source files
------------

// File: rtl/press_classifier.sv
// Classifies debounced presses into short / double / long events (+ optional auto-repeat).
// Optional feature macro: PRESS_REPEAT_EN enables repeat_press pulses while a long press is held.
module press_classifier #(
  parameter int LONG_CYCLES   = 1000,
  parameter int DOUBLE_GAP    = 200,
  parameter int REPEAT_CYCLES = 100,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_press,
  output logic busy
);

  typedef enum logic [2:0] {IDLE, PRESS1, GAP, PRESS2, HELD} state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             short_reg, short_next;
  logic             double_reg, double_next;
  logic             long_reg, long_next;
  logic             busy_reg;

`ifdef PRESS_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic repeat_reg, repeat_next;
`endif

  // Saturating increment: the counter never wraps even if thresholds are misconfigured.
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    short_next  = 1'b0;
    double_next = 1'b0;
    long_next   = 1'b0;
`ifdef PRESS_REPEAT_EN
    repeat_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (sig_in) begin
          state_next = PRESS1;
          cnt_next   = CNT_ONE;
        end
      end
      PRESS1: begin
        if (sig_in) begin
          if (cnt_reg >= LONG_LAST) begin
            long_next  = 1'b1;
            state_next = HELD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end else if (DOUBLE_GAP <= 1) begin
          // The releasing low sample already exhausts a one-sample gap.
          short_next = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          state_next = GAP;
          cnt_next   = CNT_ONE;
        end
      end
      GAP: begin
        if (sig_in) begin
          double_next = 1'b1;
          state_next  = PRESS2;
          cnt_next    = '0;
        end else if (cnt_reg >= GAP_LAST) begin
          short_next = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESS2: begin
        if (!sig_in) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      HELD: begin
        if (!sig_in) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
`ifdef PRESS_REPEAT_EN
        // HELD reuses the main counter as the repeat period counter.
        else if (cnt_reg >= REP_LAST) begin
          repeat_next = 1'b1;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_inc;
        end
`endif
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      short_reg  <= 1'b0;
      double_reg <= 1'b0;
      long_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      short_reg  <= short_next;
      double_reg <= double_next;
      long_reg   <= long_next;
      busy_reg   <= (state_next != IDLE);
    end
  end

`ifdef PRESS_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      repeat_reg <= 1'b0;
    end else begin
      repeat_reg <= repeat_next;
    end
  end
  assign repeat_press = repeat_reg;
`else
  assign repeat_press = 1'b0;
`endif

  assign short_press  = short_reg;
  assign double_press = double_reg;
  assign long_press   = long_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier: stimulus pushes expected events, a monitor pops and compares.
module tb_press_classifier;

  localparam int LC = 8;
  localparam int DG = 4;
  localparam int RC = 3;

  localparam int K_SHORT  = 0;
  localparam int K_DOUBLE = 1;
  localparam int K_LONG   = 2;
  localparam int K_REPEAT = 3;

  typedef struct {
    int edge_no;
    int kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b0;
  logic short_press, double_press, long_press, repeat_press, busy;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  press_classifier #(
    .LONG_CYCLES  (LC),
    .DOUBLE_GAP   (DG),
    .REPEAT_CYCLES(RC),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .short_press (short_press),
    .double_press(double_press),
    .long_press  (long_press),
    .repeat_press(repeat_press),
    .busy        (busy)
  );

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input int actual, input int required);
    n_checks++;
    if (actual != required) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (edge %0d)", name, actual, required, edge_cnt);
    end
  endtask

  // Monitor: every cycle, compare presented pulses against the scoreboard head.
  logic [3:0] pulses;
  int         kind_seen;
  exp_t       head;
  always @(negedge clk) begin
    pulses = {repeat_press, long_press, double_press, short_press};
    if (pulses != 4'b0000) begin
      kind_seen = 0;
      for (int b = 3; b >= 0; b--) if (pulses[b]) kind_seen = b;
      check("pulse_onehot", $countones(pulses), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_event", kind_seen, -1);
      end else begin
        head = exp_q.pop_front();
        check("event_kind", kind_seen, head.kind);
        check("event_edge", edge_cnt, head.edge_no);
        $display("event kind=%0d at edge %0d (expected kind=%0d edge %0d)",
                 kind_seen, edge_cnt, head.kind, head.edge_no);
      end
    end else if (exp_q.size() > 0 && exp_q[0].edge_no < edge_cnt) begin
      head = exp_q.pop_front();
      check("missing_event", -1, head.kind);
    end
  end

  task automatic drive(input logic v, input int n, output int last);
    last = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sig_in = v;
      last = edge_cnt + 1;
    end
  endtask

  task automatic expect_ev(input int kind, input int edge_no);
    exp_t e;
    e.kind    = kind;
    e.edge_no = edge_no;
    exp_q.push_back(e);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_short"}, short_press, 0);
    check({name, "_double"}, double_press, 0);
    check({name, "_long"}, long_press, 0);
    check({name, "_repeat"}, repeat_press, 0);
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_quiet(name);
    rst    = 1'b0;
    sig_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int l;
  initial begin
    repeat (3) @(negedge clk);
    check_quiet("reset_state");
    rst = 1'b0;

    // Short press: 3 high, 4 low
    drive(1'b1, 3, l);
    check("short_busy_pressed", busy, 1);
    drive(1'b0, 4, l);
    expect_ev(K_SHORT, l);
    drive(1'b0, 1, l);
    check("short_busy_after", busy, 0);
    drive(1'b0, 2, l);

    // Double press: high 3, low 2, high 2, low
    drive(1'b1, 3, l);
    drive(1'b0, 2, l);
    drive(1'b1, 1, l);
    expect_ev(K_DOUBLE, l);
    drive(1'b1, 1, l);
    drive(1'b0, 7, l);
    check("double_idle_busy", busy, 0);

    // Long boundary minus one: 7 high is still a short press
    drive(1'b1, 7, l);
    drive(1'b0, 4, l);
    expect_ev(K_SHORT, l);
    drive(1'b0, 2, l);

    // Long boundary: 8 high, release emits nothing
    drive(1'b1, 8, l);
    expect_ev(K_LONG, l);
    drive(1'b0, 1, l);
    drive(1'b0, 6, l);
    check("long_idle_busy", busy, 0);

    // Held 16 samples: long at 8, repeats at 11 and 14 when enabled
    drive(1'b1, 8, l);
    expect_ev(K_LONG, l);
`ifdef PRESS_REPEAT_EN
    expect_ev(K_REPEAT, l + RC);
    expect_ev(K_REPEAT, l + 2 * RC);
`endif
    drive(1'b1, 8, l);
    drive(1'b0, 6, l);

    // High immediately after gap expiry starts a fresh press
    drive(1'b1, 2, l);
    drive(1'b0, 4, l);
    expect_ev(K_SHORT, l);
    drive(1'b1, 1, l);
    drive(1'b0, 4, l);
    expect_ev(K_SHORT, l);
    drive(1'b0, 2, l);

    // Third fast press after a double is a new sequence
    drive(1'b1, 1, l);
    drive(1'b0, 1, l);
    drive(1'b1, 1, l);
    expect_ev(K_DOUBLE, l);
    drive(1'b0, 1, l);
    drive(1'b1, 1, l);
    drive(1'b0, 4, l);
    expect_ev(K_SHORT, l);
    drive(1'b0, 2, l);

    // Reset mid-press (PRESS1, cnt=5): no event afterwards
    drive(1'b1, 5, l);
    pulse_reset("rst_press1");
    drive(1'b0, 10, l);

    // Reset in GAP
    drive(1'b1, 2, l);
    drive(1'b0, 2, l);
    pulse_reset("rst_gap");
    drive(1'b0, 8, l);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
